// File: rtl/multi_bank_cache_loader_pkg.sv
// Shared types and sizing helpers for the multi-bank cache fill path.
package pkg_cache_loader;

  typedef enum logic {FILL, DONE} state_t;

  typedef enum logic {BANK_MAJOR, INTERLEAVED} bank_mode_t;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int count_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_bits(int num_banks);
    return count_bits(num_banks);
  endfunction

  function automatic int total_entries(int depth, int num_banks);
    return depth * num_banks;
  endfunction

endpackage

// File: rtl/multi_bank_cache_loader_beat_packer.sv
// Collects PACK narrow beats into one wide word, first beat in the LSBs.
module beat_packer
  import pkg_cache_loader::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int PACK     = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     accept,
  input  logic [IN_WIDTH-1:0]      data,
  output logic [IN_WIDTH*PACK-1:0] word,
  output logic                     word_valid
);

  localparam int CW = count_bits(PACK);

  logic [CW-1:0]            cnt_q;
  logic [IN_WIDTH*PACK-1:0] hold_q;
  logic                     last;

  assign last       = (cnt_q == CW'(PACK - 1));
  assign word_valid = accept && last;

  // Held beats with the current beat inserted at its slot; complete on the last beat.
  always_comb begin
    word = hold_q;
    for (int unsigned k = 0; k < PACK; k++) begin
      if (cnt_q == CW'(k)) word[k*IN_WIDTH +: IN_WIDTH] = data;
    end
  end

  // Beat counter and holding register; clear only rewinds the counter since stale slots get overwritten.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (accept) begin
      hold_q <= word;
      cnt_q  <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multi_bank_cache_loader.sv
// Fills NUM_BANKS cache banks from a packed beat stream; re-armable via reload.
module multi_bank_cache_loader
  import pkg_cache_loader::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int PACK       = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [IN_WIDTH-1:0]      data,
  input  logic                     data_ready,
  output logic                     data_wanted,
  input  logic                     reload,
  output logic [NUM_BANKS-1:0]     we,
  output logic [ADDR_WIDTH-1:0]    waddr,
  output logic [IN_WIDTH*PACK-1:0] wdata,
  output logic                     loaded
);

  localparam int         WORD_SIZE = IN_WIDTH * PACK;
  localparam int         BANK_BITS = bank_bits(NUM_BANKS);
  localparam bank_mode_t MODE      = (BANK_MODE == 1) ? INTERLEAVED : BANK_MAJOR;

  state_t                state_q, state_d;
  logic                  armed_q;
  logic [BANK_BITS-1:0]  bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_BANKS-1:0]  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic                  loaded_q;

  logic                  take;
  logic [WORD_SIZE-1:0]  word;
  logic                  word_valid;
  logic                  bank_last, addr_last, final_word;

  // armed_q keeps data_wanted low through reset while the state already sits in FILL.
  assign data_wanted = armed_q && (state_q == FILL);
  assign take        = data_ready && data_wanted && !reload;
  assign bank_last   = (bank_q == BANK_BITS'(NUM_BANKS - 1));
  assign addr_last   = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign final_word  = word_valid && bank_last && addr_last;

  assign we     = we_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign loaded = loaded_q;

  beat_packer #(
    .IN_WIDTH (IN_WIDTH),
    .PACK     (PACK)
  ) u_packer (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (reload),
    .accept     (take),
    .data       (data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Next-state: reload always returns to FILL; the last entry ends the fill.
  always_comb begin
    state_d = state_q;
    if (reload)                                state_d = FILL;
    else if (state_q == FILL && final_word)    state_d = DONE;
  end

  // State register and reset-release flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FILL;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Bank/address counters: inner counter wraps and carries into the outer one.
  always_ff @(posedge clk) begin
    if (!resetn || reload) begin
      bank_q <= '0;
      addr_q <= '0;
    end else if (word_valid) begin
      if (MODE == BANK_MAJOR) begin
        if (addr_last) begin
          addr_q <= '0;
          bank_q <= bank_last ? '0 : bank_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end else begin
        if (bank_last) begin
          bank_q <= '0;
          addr_q <= addr_last ? '0 : addr_q + 1'b1;
        end else begin
          bank_q <= bank_q + 1'b1;
        end
      end
    end
  end

  // Write port register: one-cycle strobe, address/data held until the next write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      we_q <= word_valid ? (NUM_BANKS'(1) << bank_q) : '0;
      if (word_valid) begin
        waddr_q <= addr_q;
        wdata_q <= word;
      end
      if (reload)          loaded_q <= 1'b0;
      else if (final_word) loaded_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_bank_cache_loader.sv
// Scoreboard bench: three loader configurations share one stimulus stream.
module tb_multi_bank_cache_loader;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data;
  logic       data_ready;
  logic       reload;

  logic       dw_a, dw_b, dw_c;
  logic [1:0] we_a, we_b;
  logic [0:0] we_c;
  logic [1:0] waddr_a, waddr_b, waddr_c;
  logic [15:0] wdata_a, wdata_b;
  logic [7:0] wdata_c;
  logic       loaded_a, loaded_b, loaded_c;

  always #5 clk = ~clk;

  // Bank-major, 2 banks x 4 entries, 2 beats per word.
  multi_bank_cache_loader #(
    .IN_WIDTH(8), .PACK(2), .ADDR_WIDTH(2), .DEPTH(4), .NUM_BANKS(2), .BANK_MODE(0)
  ) dut_a (
    .clk(clk), .resetn(resetn), .data(data), .data_ready(data_ready),
    .data_wanted(dw_a), .reload(reload), .we(we_a), .waddr(waddr_a),
    .wdata(wdata_a), .loaded(loaded_a)
  );

  // Interleaved, same geometry.
  multi_bank_cache_loader #(
    .IN_WIDTH(8), .PACK(2), .ADDR_WIDTH(2), .DEPTH(4), .NUM_BANKS(2), .BANK_MODE(1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .data(data), .data_ready(data_ready),
    .data_wanted(dw_b), .reload(reload), .we(we_b), .waddr(waddr_b),
    .wdata(wdata_b), .loaded(loaded_b)
  );

  // One beat per word, single bank of 3 entries.
  multi_bank_cache_loader #(
    .IN_WIDTH(8), .PACK(1), .ADDR_WIDTH(2), .DEPTH(3), .NUM_BANKS(1), .BANK_MODE(0)
  ) dut_c (
    .clk(clk), .resetn(resetn), .data(data), .data_ready(data_ready),
    .data_wanted(dw_c), .reload(reload), .we(we_c), .waddr(waddr_c),
    .wdata(wdata_c), .loaded(loaded_c)
  );

  typedef struct {
    int          cycle;
    int          bank;
    int          addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model configuration and state, one slot per DUT.
  int pk[3]  = '{2, 2, 1};
  int dp[3]  = '{4, 4, 3};
  int nbk[3] = '{2, 2, 1};
  int md[3]  = '{0, 1, 0};

  int          nb[3];
  int          ent[3];
  bit          done[3];
  bit          armed[3];
  bit          expl[3];
  bit          acc[3];
  logic [15:0] wb[3];

  int cyc      = 0;
  bit started  = 1'b0;
  bit in_reset = 1'b1;
  int nxt      = 0;

  task automatic check(string nm, int m, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h (cycle %0d)", m, nm, act, expv, cyc);
    end
  endtask

  task automatic qpush(int m, exp_t x);
    case (m)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  function automatic int qsize(int m);
    case (m)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int m);
    case (m)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int qhead_cycle(int m);
    case (m)
      0: return q0[0].cycle;
      1: return q1[0].cycle;
      default: return q2[0].cycle;
    endcase
  endfunction

  // Reference model: count accepted beats, derive entry index, map to (bank, addr) arithmetically.
  always @(posedge clk) begin
    exp_t x;
    cyc++;
    started  = 1'b1;
    in_reset = !resetn;
    for (int m = 0; m < 3; m++) begin
      acc[m] = 1'b0;
      if (!resetn) begin
        nb[m] = 0; ent[m] = 0; done[m] = 0; armed[m] = 0; expl[m] = 0; wb[m] = '0;
      end else begin
        if (reload) begin
          nb[m] = 0; ent[m] = 0; done[m] = 0; expl[m] = 0; wb[m] = '0;
        end else if (armed[m] && !done[m] && data_ready) begin
          acc[m] = 1'b1;
          wb[m]  = wb[m] | (16'(data) << (8 * nb[m]));
          nb[m]++;
          if (nb[m] == pk[m]) begin
            x.cycle = cyc;
            x.bank  = md[m] ? ent[m] % nbk[m] : ent[m] / dp[m];
            x.addr  = md[m] ? ent[m] / nbk[m] : ent[m] % dp[m];
            x.wdata = wb[m];
            qpush(m, x);
            if (ent[m] == dp[m] * nbk[m] - 1) begin
              done[m] = 1'b1;
              expl[m] = 1'b1;
            end
            ent[m]++;
            nb[m] = 0;
            wb[m] = '0;
          end
        end
        armed[m] = 1'b1;
      end
    end
  end

  task automatic mon(int m, logic [1:0] we, logic [1:0] wa, logic [15:0] wd, logic ld, logic dw);
    exp_t x;
    if (in_reset) begin
      check("reset_we", m, 32'(we), 0);
      check("reset_waddr", m, 32'(wa), 0);
      check("reset_wdata", m, 32'(wd), 0);
      check("reset_loaded", m, 32'(ld), 0);
      check("reset_data_wanted", m, 32'(dw), 0);
    end else begin
      check("data_wanted", m, 32'(dw), 32'(armed[m] && !done[m]));
      check("loaded", m, 32'(ld), 32'(expl[m]));
      if (we != '0) begin
        if (qsize(m) == 0) begin
          check("spurious_we", m, 32'(we), 0);
        end else begin
          x = qpop(m);
          check("we_bank", m, 32'(we), 32'(1) << x.bank);
          check("waddr", m, 32'(wa), 32'(x.addr));
          check("wdata", m, 32'(wd), 32'(x.wdata));
          check("we_latency", m, 32'(cyc), 32'(x.cycle));
        end
      end else if (qsize(m) != 0 && qhead_cycle(m) <= cyc) begin
        x = qpop(m);
        check("missing_we", m, 0, 1);
      end
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      mon(0, we_a, waddr_a, wdata_a, loaded_a, dw_a);
      mon(1, we_b, waddr_b, wdata_b, loaded_b, dw_b);
      mon(2, {1'b0, we_c}, waddr_c, {8'h00, wdata_c}, loaded_c, dw_c);
    end
  end

  // Stream n beats as seen by dut_a, data counting from 0; stall_pct% of cycles idle.
  task automatic fill(int n_beats, int stall_pct);
    int sent  = 0;
    int guard = 0;
    nxt = 0;
    while (sent < n_beats && guard < 2000) begin
      data_ready = ($urandom_range(99) >= stall_pct);
      data       = 8'(nxt);
      reload     = 1'b0;
      @(posedge clk); #1;
      if (acc[0]) begin
        sent++;
        nxt++;
      end
      guard++;
    end
    data_ready = 1'b0;
    n_checks++;
    if (sent < n_beats) begin
      n_fail++;
      $display("FAIL fill_budget: got %0d beats accepted required %0d", sent, n_beats);
    end
  endtask

  task automatic idle(int k);
    data_ready = 1'b0;
    reload     = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reload(bit rdy);
    reload     = 1'b1;
    data_ready = rdy;
    data       = 8'(nxt);
    @(posedge clk); #1;
    reload     = 1'b0;
    data_ready = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    data       = '0;
    data_ready = 1'b0;
    reload     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Basic continuous fill, then reload from DONE and a stalled refill.
    fill(16, 0);
    idle(3);
    pulse_reload(1'b0);
    fill(16, 40);
    idle(3);

    // Reload after five beats drops the half word; then a full refill.
    pulse_reload(1'b0);
    fill(5, 0);
    pulse_reload(1'b1);
    fill(16, 0);
    idle(2);

    // Random traffic with occasional reloads.
    pulse_reload(1'b0);
    for (int i = 0; i < 300; i++) begin
      data_ready = $urandom_range(3) != 0;
      data       = 8'($urandom);
      reload     = ($urandom_range(49) == 0);
      @(posedge clk); #1;
    end
    idle(2);

    // Reset mid-fill, then a stalled full fill.
    pulse_reload(1'b0);
    fill(3, 0);
    resetn = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    resetn = 1'b1;
    fill(16, 30);
    idle(4);

    for (int m = 0; m < 3; m++) check("queue_drained", m, 32'(qsize(m)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_bank_cache_loader.md
# multi_bank_cache_loader

Parametrised successor to the single-array feature-cache fill path. The block accepts a narrow word stream on a ready/wanted handshake and packs `PACK` beats into one cache word. It writes the words across `NUM_BANKS` independent cache banks in either bank-major or interleaved order. It raises `loaded` when every entry of every bank has been written, and can be re-armed by `reload` without a reset, so the detector can swap feature sets between frames.

## Interface
Parameters:
- `IN_WIDTH`, 16: width of one input beat.
- `PACK`, 2: beats per cache word, ≥1; `WORD_SIZE = IN_WIDTH*PACK`.
- `ADDR_WIDTH`, 10: bank address width.
- `DEPTH`, 1024: entries per bank, 1..2**ADDR_WIDTH.
- `NUM_BANKS`, 4: number of banks, ≥1.
- `BANK_MODE`, 0: 0 = bank-major, 1 = interleaved.

Ports:
- `clk`, in, 1: single clock. One clock; all logic on the rising edge.
- `resetn`, in, 1: reset is synchronous and active-low.
- `data`, in, IN_WIDTH: input beat.
- `data_ready`, in, 1: source holds a valid beat.
- `data_wanted`, out, 1: loader accepts a beat this cycle.
- `reload`, in, 1: single-cycle pulse that restarts the fill from entry 0.
- `we`, out, NUM_BANKS: one-hot bank write strobe.
- `waddr`, out, ADDR_WIDTH: write address, shared by all banks.
- `wdata`, out, WORD_SIZE: write data, shared by all banks.
- `loaded`, out, 1: all `DEPTH*NUM_BANKS` entries have been written.

## Operation
- A beat transfers on any cycle where `data_ready && data_wanted`.
- Packing: beat k (0..PACK-1) of a word lands in `wdata[k*IN_WIDTH +: IN_WIDTH]`, so the first beat is in the LSBs. A beat counter counts 0..PACK-1 and wraps.
- FSM states:
  - `FILL`: `data_wanted`=1. On the accepted beat with counter=PACK-1, the completed word is registered and the entry counter advances. When the accepted word is entry `DEPTH*NUM_BANKS-1`, go to `DONE`.
  - `DONE`: `data_wanted`=0 and `loaded`=1. Further `data_ready` is ignored.
- Entry order:
  - Bank-major (`BANK_MODE`=0): bank 0 addresses 0..DEPTH-1, then bank 1, and so on.
  - Interleaved (`BANK_MODE`=1): address 0 in banks 0..NUM_BANKS-1, then address 1, and so on.
  - Bank and address are separate counters; the inner counter wraps and carries into the outer one. There are no multipliers.
- `reload` behaviour:
  - In any state, `reload` clears the beat, bank and address counters, discards any partial word, clears `loaded` and enters `FILL` on the next cycle.
  - A beat accepted in the same cycle as `reload` is discarded.
  - A write already registered on the previous cycle still issues.
- No back-pressure comes from the banks: every strobe is one write.

## Timing
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `loaded`=0, `data_wanted`=0 while `resetn`=0. The state is `FILL`, so `data_wanted`=1 on the first cycle after `resetn` returns high.
- `data_wanted` is decoded from registered state only. It does not depend combinationally on `data_ready`.
- Write latency: `we` pulses for exactly 1 cycle, on the cycle after the last beat of a word is accepted. `waddr` and `wdata` are valid with it and hold until the next write.
- Throughput: one beat per cycle with no bubbles, so one write every PACK cycles at full rate.
- `loaded` rises in the same cycle as the final `we` pulse.
- `data_wanted` drops on the cycle after the final beat is accepted.
- PACK=1: every accepted beat produces a write one cycle later.
- Reset mid-fill: all state returns to reset values on the next edge, and no `we` is produced for a partial word.

## Structure
- Package `pkg_cache_loader`:
  - `typedef enum {FILL, DONE} state_t`
  - `typedef enum {BANK_MAJOR, INTERLEAVED} bank_mode_t`
  - Localparam helpers: `BANK_BITS = $clog2(NUM_BANKS)` (minimum 1), `TOTAL_ENTRIES`.
- Sub-module `beat_packer`: holds the beat counter and the shift/insert register. It outputs `word` and `word_valid` (asserted on the last beat) and has a `clear` input driven by `reload`.
- The top level holds the FSM, the bank/address counters and the output register.

## Test plan
- **Reset and basic fill.** Parameters IN_WIDTH=8, PACK=2, DEPTH=4, NUM_BANKS=2, BANK_MODE=0. Hold reset, then stream bytes 0x00..0x0F continuously. Required: writes of 0x0100, 0x0302, 0x0504, 0x0706 to bank 0 at addresses 0..3. Then bank 1 receives 0x0908 through 0x0F0E. `loaded` rises with the 8th `we`, and `data_wanted` is 0 one cycle later.
- **Interleaved order.** Same stream with BANK_MODE=1. Required `(bank,addr)` sequence: (0,0), (1,0), (0,1), (1,1) … (1,3).
- **Stalls.** Randomly deassert `data_ready`. Required: written data and order identical to the first test, with no spurious `we` pulse.
- **Reload mid-fill.** Pulse `reload` after 5 beats. Required: the half-built word is dropped, the next write goes to (bank 0, addr 0) with the next two beats, and `loaded`=0.
- **Reload after done.** Pulse `reload` in `DONE`. Required: `loaded` falls and `data_wanted` returns to 1 the next cycle. A second full fill completes identically.
- **PACK=1, NUM_BANKS=1, DEPTH=3.** Send 3 beats. Required: 3 writes, each one cycle after its beat, and `loaded` rises with the 3rd write.
